// File: rtl/layer_stats_if.sv
// Bundle between the stats engine and its producer/consumer: request side
// (start, x), status (busy) and the held result with its valid/ready handshake.
interface layer_stats_if #(
    parameter int N  = 4,
    parameter int DW = 16
);
    // Handshake: start is sampled only while busy=0 and x is captured on that edge.
    // out_valid stays high with mean/stddev stable until out_valid && out_ready on a
    // rising edge. The accept is a single transfer and the engine is idle one cycle later.
    logic                 start;
    logic [N-1:0][DW-1:0] x;
    logic                 busy;
    logic [DW-1:0]        mean;
    logic [DW-1:0]        stddev;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output start, x, out_ready,
        input  busy, mean, stddev, out_valid
    );

    modport slave (
        input  start, x, out_ready,
        output busy, mean, stddev, out_valid
    );
endinterface

// File: rtl/layer_stats.sv
// Sequential mean / standard deviation of an N-element signed Q8.8 vector:
// N accumulate cycles, one variance cycle, then a 16-step restoring square root.
module layer_stats #(
    parameter int N   = 4,
    parameter int DW  = 16,
    parameter int EPS = 1
) (
    input  logic          clk,
    input  logic          rst,
    layer_stats_if.slave  bus,
    output logic [2:0]    dbg_state
);
    localparam int LG = $clog2(N);
    localparam int SW = DW + LG;
    localparam int QW = 2 * DW + LG;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACCUM = 3'd1,
        S_VAR   = 3'd2,
        S_SQRT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [N-1:0][DW-1:0] xr;
    logic [LG-1:0]        idx;
    logic signed [SW-1:0] sum;
    logic [QW-1:0]        sumsq;
    logic signed [DW-1:0] m_r;
    logic [31:0]          rad_r;
    logic [17:0]          rem;
    logic [15:0]          root;
    logic [3:0]           cnt;
    logic [DW-1:0]        mean_r;
    logic [DW-1:0]        stddev_r;

    logic signed [DW-1:0]     cur;
    logic signed [2*DW-1:0]   sq;
    logic signed [DW-1:0]     m_c;
    logic [31:0]              ex2;
    logic signed [2*DW-1:0]   mm;
    logic signed [2*DW+1:0]   var_s;
    logic [31:0]              var_c;
    logic [32:0]              rad_w;
    logic [31:0]              rad_c;
    logic [19:0]              shifted;
    logic [19:0]              trial;
    logic                     ge;
    logic [17:0]              rem_nxt;
    logic [15:0]              root_nxt;
    logic [15:0]              sd_c;

    // Accumulate / variance arithmetic
    always_comb begin
        cur   = xr[idx];
        sq    = cur * cur;
        m_c   = DW'(sum >>> LG);
        ex2   = 32'(sumsq >> LG);
        mm    = m_c * m_c;
        var_s = $signed({2'b00, ex2}) - $signed({2'b00, mm});
        var_c = var_s[2*DW+1] ? 32'd0 : 32'(var_s);
        rad_w = {1'b0, var_c} + 33'(EPS);
        rad_c = rad_w[32] ? 32'hFFFF_FFFF : rad_w[31:0];
    end

    // One restoring square-root step: bring down two radicand bits, try 4*root+1
    always_comb begin
        shifted  = {rem, rad_r[31:30]};
        trial    = {2'b00, root, 2'b01};
        ge       = (shifted >= trial);
        rem_nxt  = ge ? 18'(shifted - trial) : 18'(shifted);
        root_nxt = {root[14:0], ge};
        if (root_nxt > 16'h7FFF)
            sd_c = 16'h7FFF;
        else if (root_nxt == 16'd0)
            sd_c = 16'd1;
        else
            sd_c = root_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start) state_nxt = S_ACCUM;
            S_ACCUM: if (idx == LG'(N - 1)) state_nxt = S_VAR;
            S_VAR:   state_nxt = S_SQRT;
            S_SQRT:  if (cnt == 4'd15) state_nxt = S_DONE;
            S_DONE:  if (bus.out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = (state != S_IDLE);
        bus.out_valid = (state == S_DONE);
        bus.mean      = mean_r;
        bus.stddev    = stddev_r;
        dbg_state     = state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xr       <= '0;
            idx      <= '0;
            sum      <= '0;
            sumsq    <= '0;
            m_r      <= '0;
            rad_r    <= '0;
            rem      <= '0;
            root     <= '0;
            cnt      <= '0;
            mean_r   <= '0;
            stddev_r <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        xr    <= bus.x;
                        sum   <= '0;
                        sumsq <= '0;
                        idx   <= '0;
                    end
                end
                S_ACCUM: begin
                    sum   <= sum + {{LG{cur[DW-1]}}, cur};
                    sumsq <= sumsq + {{LG{1'b0}}, sq};
                    idx   <= idx + 1'b1;
                end
                S_VAR: begin
                    m_r   <= m_c;
                    rad_r <= rad_c;
                    rem   <= '0;
                    root  <= '0;
                    cnt   <= '0;
                end
                S_SQRT: begin
                    rad_r <= rad_r << 2;
                    rem   <= rem_nxt;
                    root  <= root_nxt;
                    cnt   <= cnt + 1'b1;
                    if (cnt == 4'd15) begin
                        mean_r   <= m_r;
                        stddev_r <= sd_c;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_layer_stats.sv
// Randomized and directed bench for layer_stats, checked against an arithmetic
// reference model of mean/stddev and a scoreboard queue of expected results.
module tb_layer_stats;
    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    layer_stats_if #(.N(4), .DW(16)) bus();

    layer_stats #(.N(4), .DW(16), .EPS(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    // Reference: floor mean, population variance, +EPS, integer sqrt, clamp to [1, 0x7FFF]
    function automatic logic [31:0] model(input logic [3:0][15:0] v);
        longint s, sq, m, ex2, vr, rad, r, xi;
        s  = 0;
        sq = 0;
        for (int i = 0; i < 4; i++) begin
            xi = longint'($signed(v[i]));
            s  += xi;
            sq += xi * xi;
        end
        m   = (s >= 0) ? s / 4 : -((-s + 3) / 4);
        ex2 = sq / 4;
        vr  = ex2 - m * m;
        if (vr < 0) vr = 0;
        rad = vr + 1;
        if (rad > 64'hFFFF_FFFF) rad = 64'hFFFF_FFFF;
        r = longint'($floor($sqrt(real'(rad))));
        while (r * r > rad) r--;
        while ((r + 1) * (r + 1) <= rad) r++;
        if (r > 32767) r = 32767;
        if (r < 1) r = 1;
        return {m[15:0], r[15:0]};
    endfunction

    task automatic launch(input logic [3:0][15:0] v);
        @(negedge clk);
        bus.x     = v;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic accept();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        bus.x         = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.mean !== 16'h0000) begin errors++; $display("FAIL reset_mean: got %h expected 0000", bus.mean); end
        checks++; if (bus.stddev !== 16'h0000) begin errors++; $display("FAIL reset_stddev: got %h expected 0000", bus.stddev); end
        checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [3:0][15:0] vecs [4];
        logic [31:0]      want [4];
        logic [31:0]      e;
        int               lat;
        vecs[0] = {16'h0100, 16'h0100, 16'h0100, 16'h0100}; want[0] = {16'h0100, 16'h0001};
        vecs[1] = {16'h0100, 16'hFF00, 16'h0100, 16'hFF00}; want[1] = {16'h0000, 16'h0100};
        vecs[2] = {16'h0200, 16'h0400, 16'h0400, 16'h0600}; want[2] = {16'h0400, 16'h016A};
        vecs[3] = {16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000}; want[3] = {16'hFFFF, 16'h7FFF};
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(want[i]);
            launch(vecs[i]);
            wait_valid(lat);
            e = exp_q.pop_front();
            checks++; if (lat !== 21) begin errors++; $display("FAIL dir%0d_latency: got %0d expected 21", i, lat); end
            checks++; if (bus.mean !== e[31:16]) begin errors++; $display("FAIL dir%0d_mean: got %h expected %h", i, bus.mean, e[31:16]); end
            checks++; if (bus.stddev !== e[15:0]) begin errors++; $display("FAIL dir%0d_stddev: got %h expected %h", i, bus.stddev, e[15:0]); end
            accept();
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL dir%0d_drop: got %b expected 0", i, bus.out_valid); end
            checks++; if (bus.mean !== e[31:16]) begin errors++; $display("FAIL dir%0d_keep_mean: got %h expected %h", i, bus.mean, e[31:16]); end
        end
    endtask

    task automatic test_hold();
        logic [3:0][15:0] v3, v1;
        logic [31:0]      e;
        int               lat;
        v3 = {16'h0200, 16'h0400, 16'h0400, 16'h0600};
        v1 = {16'h0100, 16'h0100, 16'h0100, 16'h0100};
        exp_q.push_back(model(v3));
        launch(v3);
        wait_valid(lat);
        e = exp_q.pop_front();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid_timeout: got %b expected 1", bus.out_valid); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            bus.start = 1'b1;
            bus.x     = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
            @(posedge clk);
            #1;
            checks++; if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("FAIL hold%0d_flags: got valid=%b busy=%b expected 1 1", c, bus.out_valid, bus.busy); end
            checks++; if ({bus.mean, bus.stddev} !== e) begin errors++; $display("FAIL hold%0d_data: got %h expected %h", c, {bus.mean, bus.stddev}, e); end
        end
        bus.start = 1'b0;
        accept();
        checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL hold_release: got valid=%b busy=%b expected 0 0", bus.out_valid, bus.busy); end
        exp_q.push_back(model(v1));
        launch(v1);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL hold_restart_busy: got %b expected 1", bus.busy); end
        wait_valid(lat);
        e = exp_q.pop_front();
        checks++; if (lat !== 21) begin errors++; $display("FAIL hold_restart_latency: got %0d expected 21", lat); end
        checks++; if ({bus.mean, bus.stddev} !== e) begin errors++; $display("FAIL hold_restart_data: got %h expected %h", {bus.mean, bus.stddev}, e); end
        accept();
    endtask

    task automatic test_reset_mid();
        logic [3:0][15:0] v2, v3;
        logic [31:0]      e;
        int               lat;
        v2 = {16'h0100, 16'hFF00, 16'h0100, 16'hFF00};
        v3 = {16'h0200, 16'h0400, 16'h0400, 16'h0600};
        launch(v2);
        repeat (8) @(posedge clk);
        #1;
        checks++; if (dbg_state !== 3'd3) begin errors++; $display("FAIL midrst_in_sqrt: got %0d expected 3", dbg_state); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_flags: got busy=%b valid=%b expected 0 0", bus.busy, bus.out_valid); end
        checks++; if ({bus.mean, bus.stddev} !== 32'h0) begin errors++; $display("FAIL midrst_data: got %h expected 00000000", {bus.mean, bus.stddev}); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(model(v3));
        launch(v3);
        wait_valid(lat);
        e = exp_q.pop_front();
        checks++; if (lat !== 21) begin errors++; $display("FAIL midrst_latency: got %0d expected 21", lat); end
        checks++; if ({bus.mean, bus.stddev} !== e) begin errors++; $display("FAIL midrst_data_after: got %h expected %h", {bus.mean, bus.stddev}, e); end
        accept();
    endtask

    task automatic test_random();
        logic [3:0][15:0] v;
        logic [31:0]      e;
        int               lat, mode, dly;
        logic [15:0]      base;
        for (int n = 0; n < 40; n++) begin
            mode = $urandom_range(0, 2);
            base = 16'($urandom);
            for (int i = 0; i < 4; i++) begin
                case (mode)
                    0:       v[i] = 16'($urandom_range(0, 65535));
                    1:       v[i] = 16'(int'($urandom_range(0, 1023)) - 512);
                    default: v[i] = base + 16'($urandom_range(0, 7));
                endcase
            end
            exp_q.push_back(model(v));
            launch(v);
            wait_valid(lat);
            e = exp_q.pop_front();
            checks++; if (lat !== 21) begin errors++; $display("FAIL rnd%0d_latency: got %0d expected 21", n, lat); end
            checks++; if (bus.mean !== e[31:16]) begin errors++; $display("FAIL rnd%0d_mean: got %h expected %h (x=%h)", n, bus.mean, e[31:16], v); end
            checks++; if (bus.stddev !== e[15:0]) begin errors++; $display("FAIL rnd%0d_stddev: got %h expected %h (x=%h)", n, bus.stddev, e[15:0], v); end
            dly = $urandom_range(0, 3);
            repeat (dly) @(posedge clk);
            #1;
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rnd%0d_held: got %b expected 1", n, bus.out_valid); end
            accept();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
